// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data requester and memory-side signal bundle.
// slave = arbiter view, master = CPU/memory environment view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_rdata, mem_ready,
    output i_rdata, i_ack, i_err,
    output d_rdata, d_ack, d_err,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_rdata, mem_ready,
    input  i_rdata, i_ack, i_err,
    input  d_rdata, d_ack, d_err,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters.
// Optional memory wait timeout enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int FIXED_DATA_PRIO = 0,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE, GRANT_I, GRANT_D, ACK
  } state_t;

  state_t        state_q, state_d;
  logic          last_d_q, last_d_d;
  logic          win_d_q, win_d_d;
  logic          we_q, we_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pick_d;
  logic          granted;
  logic          tmo;

  assign granted = (state_q == GRANT_I)
                || (state_q == GRANT_D);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || state_q == IDLE)
      cnt_q <= '0;
    else if (granted)
      cnt_q <= cnt_q + CW'(1);
  end

  // last grant cycle: counter has seen TIMEOUT_CYCLES-1 waits
  assign tmo = granted
            && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    state_d   = state_q;
    last_d_d  = last_d_q;
    win_d_d   = win_d_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    pick_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_req || bus.d_req) begin
          // on a tie, round-robin grants the port not served last
          pick_d  = bus.d_req
                 && (!bus.i_req
                  || FIXED_DATA_PRIO != 0
                  || !last_d_q);
          win_d_d = pick_d;
          err_d   = 1'b0;
          addr_d  = pick_d ? bus.d_addr : bus.i_addr;
          we_d    = pick_d && bus.d_we;
          wdata_d = pick_d ? bus.d_wdata : wdata_q;
          state_d = pick_d ? GRANT_D : GRANT_I;
        end
      end
      GRANT_I, GRANT_D: begin
        if (bus.mem_ready) begin
          if (!we_q) begin
            if (win_d_q) d_rdata_d = bus.mem_rdata;
            else         i_rdata_d = bus.mem_rdata;
          end
          last_d_d = win_d_q;
          state_d  = ACK;
        end else if (tmo) begin
          if (win_d_q) d_rdata_d = '0;
          else         i_rdata_d = '0;
          err_d    = 1'b1;
          last_d_d = win_d_q;
          state_d  = ACK;
        end
      end
      ACK: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_d_q  <= 1'b0;
      win_d_q   <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_d_q  <= last_d_d;
      win_d_q   <= win_d_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.mem_req   = granted;
  assign bus.mem_we    = (state_q == GRANT_D) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.i_ack     = (state_q == ACK) && !win_d_q;
  assign bus.d_ack     = (state_q == ACK) && win_d_q;
  assign bus.i_err     = bus.i_ack && err_q;
  assign bus.d_err     = bus.d_ack && err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the CPU's instruction-fetch port and data port. The CPU otherwise drives these as two independent memories.
- Sits between the CPU top and the memory model/controller.
- Each requester uses a req/ack handshake. The arbiter serializes accesses, registers read data, and handles variable memory latency through mem_ready.

Parameters:
- AW, 32, address width (byte address, passed through unchanged)
- DW, 32, data width
- FIXED_DATA_PRIO, 0, 1 = data port always wins ties; 0 = round-robin on ties
- TIMEOUT_CYCLES, 255, memory wait limit; used only with MEM_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction fetch request; held until i_ack
- i_addr  in  AW  fetch address; stable while i_req=1
- i_rdata  out  DW  fetched word; valid in the i_ack cycle, held afterwards
- i_ack  out  1  one-cycle completion pulse
- d_req  in  1  data access request; held until d_ack
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_rdata  out  DW  read data; valid in the d_ack cycle, held afterwards
- d_ack  out  1  one-cycle completion pulse
- mem_req  out  1  memory access strobe; held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data; valid when mem_ready=1
- mem_ready  in  1  memory completion; sampled only while mem_req=1
- busy  out  1  high in any state other than IDLE
- i_err, d_err  out  1  timeout error pulses (see Optional Feature)

Behaviour:
- Reset (synchronous, active-high): state=IDLE, last_grant=INSTR.
  - Outputs after reset: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, i_ack=0, d_ack=0, i_rdata=0, d_rdata=0, busy=0, errors=0.
- FSM states: IDLE, GRANT_I, GRANT_D, ACK.
  - IDLE: at the edge where a req=1, latch winner, addr, we and wdata into registers; go to GRANT_I or GRANT_D.
  - GRANT_x: mem_req=1 and registered outputs driven. mem_we=1 only in GRANT_D with d_we=1. At the edge where mem_ready=1: capture mem_rdata into the winner's rdata (reads only; writes leave rdata unchanged); update last_grant; go to ACK.
  - ACK: winner's ack=1 for exactly one cycle; mem_req=0; requests ignored; next state IDLE.
- Requester rule: req must be low in the cycle after ack. The arbiter never re-samples req in the ACK cycle, so no duplicate grant occurs.
- Tie-break (both req in IDLE):
  - FIXED_DATA_PRIO=1: data wins.
  - FIXED_DATA_PRIO=0: grant the port not in last_grant. After reset, data wins the first tie.
- Latency:
  - Req high at edge N (IDLE) gives mem_req high from N+1.
  - mem_ready at edge M gives ack high in cycle M+1.
  - Minimum req-to-ack is 3 edges, with mem_ready=1 in the first grant cycle.
- mem_ready while mem_req=0 is ignored.
- A requester dropping req mid-grant does not abort the transaction; ack is still issued.
- Reset mid-transaction: next edge forces IDLE and mem_req=0. No ack is issued, and the in-flight access is abandoned.
- Addresses/data pass through without modification. There is no alignment checking.

Optional Feature:
- MEM_TIMEOUT_EN defined:
  - A cycle counter (width clog2(TIMEOUT_CYCLES+1)) clears on grant and increments in GRANT_x.
  - If it reaches TIMEOUT_CYCLES with mem_ready still 0: go to ACK, pulse ack and the winner's err together, set the winner's rdata=0, drop mem_req.
  - mem_ready arriving in the same cycle as the timeout takes precedence (normal completion, no err).
- MEM_TIMEOUT_EN undefined:
  - No counter; GRANT_x waits indefinitely.
  - i_err and d_err are tied to 0.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0000_0040, mem_ready=1 one cycle after mem_req, mem_rdata=0x2008_0005 -> mem_addr=0x40, mem_we=0, i_ack one cycle, i_rdata=0x2008_0005, d_ack never asserted.
- Data write with 3-cycle memory wait: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xCAFE_F00D -> mem_we=1 and mem_wdata=0xCAFE_F00D held for 3 cycles; d_ack follows mem_ready by one cycle; d_rdata unchanged.
- Simultaneous requests, FIXED_DATA_PRIO=0, four back-to-back rounds: grant order D,I,D,I. With FIXED_DATA_PRIO=1: D every round while both are held.
- Reset asserted during GRANT_D with mem_ready=0 -> next cycle mem_req=0, busy=0, no d_ack; a subsequent fetch completes normally.
- Ack/req protocol: requester keeps req high through the ack cycle, then drops it -> exactly one ack and one mem_req burst.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=8 and mem_ready stuck at 0 on a fetch -> after 8 grant cycles, i_ack=1 with i_err=1 and i_rdata=0. Without the macro: mem_req stays high and i_err stays 0.
